// File: rtl/free_mode_core_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : free_mode_core_if
// Purpose  : Bundles the key-decoder control and status signals so the
//            decoder core and its driver share one connection.
// Ports    : oct_sel  - octave select (0 bass, 1 mid, 2 high)
//            touch    - raw key levels, position 0 on the MSB
//            map_wr   - key-position table write strobe
//            map_idx  - logical key being remapped
//            map_pos  - new physical position for map_idx
//            note     - current note number, 0 = silence
//            playing  - a note is sounding or sustaining
//            note_start - one-cycle pulse on each new nonzero note
//            multi_err  - more than one logical key active
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
interface free_mode_core_if #(
  parameter int NKEYS  = 8,
  parameter int NOTE_W = 5,
  parameter int POS_W  = 3
);
  logic [1:0]        oct_sel;
  logic [NKEYS-1:0]  touch;
  logic              map_wr;
  logic [POS_W-1:0]  map_idx;
  logic [POS_W-1:0]  map_pos;
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              note_start;
  logic              multi_err;

  // master drives the controls (board / bench), slave is the decoder core
  modport master (
    output oct_sel, touch, map_wr, map_idx, map_pos,
    input  note, playing, note_start, multi_err
  );

  modport slave (
    input  oct_sel, touch, map_wr, map_idx, map_pos,
    output note, playing, note_start, multi_err
  );
endinterface
`default_nettype wire

// File: rtl/free_mode_core.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : free_mode_core
// Purpose  : Free-play key decoder. Synchronises and debounces an NKEYS-wide
//            touch bus, maps physical positions to logical keys through a
//            runtime-writable table, and produces a note number across NOCT
//            octaves with optional release sustain.
// Ports    : clk  - system clock
//            rst  - synchronous reset, active low
//            bus  - free_mode_core_if.slave (controls in, note/status out)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module free_mode_core #(
  parameter int NKEYS          = 8,
  parameter int NOCT           = 3,
  parameter int DEB_CYCLES     = 1000000,
  parameter int SUSTAIN_CYCLES = 0,
  parameter int NOTE_W         = 5,
  parameter int POS_W          = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  free_mode_core_if.slave    bus
);

  localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_SUS_W = (SUSTAIN_CYCLES > 2) ? $clog2(SUSTAIN_CYCLES) : 1;
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_SUS_W-1:0] c_SUS_LAST =
    c_SUS_W'((SUSTAIN_CYCLES > 0) ? SUSTAIN_CYCLES - 1 : 0);
  localparam bit               c_HAS_SUS = (SUSTAIN_CYCLES > 0);
  localparam logic [POS_W-1:0] c_MUTE    = POS_W'(NKEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_SUSTAIN = 2'd2
  } state_t;

  // note = octave*(NKEYS-1) + key + 1; invalid octave is silence
  function automatic logic [NOTE_W-1:0] f_note(input logic [POS_W-1:0] key,
                                               input logic [1:0]       oct);
    int v;
    if (int'(oct) >= NOCT) return '0;
    v = int'(oct) * (NKEYS - 1) + int'(key) + 1;
    return NOTE_W'(v);
  endfunction

  // input synchroniser, key table, decode
  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_ts;
  logic [POS_W-1:0] r_map [NKEYS];
  logic [NKEYS-1:0] w_l;
  logic             w_cand_v;
  logic [POS_W-1:0] w_cand_idx;
  logic             r_multi;

  // debounce
  logic               r_cq_v;
  logic [POS_W-1:0]   r_cq_idx;
  logic [c_DEB_W-1:0] r_cnt;
  logic               w_same;
  logic               w_commit;
  logic               w_mute;
  logic               w_keynote;

  // note FSM
  state_t             r_state, w_state_nx;
  logic [POS_W-1:0]   r_key, w_key_nx;
  logic [NOTE_W-1:0]  r_note, w_note_nx;
  logic               r_start, w_start_nx;
  logic [c_SUS_W-1:0] r_scnt, w_scnt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_ts    <= '0;
      r_multi <= 1'b0;
      for (int i = 0; i < NKEYS; i++) r_map[i] <= POS_W'(i);
    end else begin
      r_sync1 <= bus.touch;
      r_ts    <= r_sync1;
      r_multi <= (w_l & (w_l - NKEYS'(1))) != '0;
      if (bus.map_wr && (32'(bus.map_idx) < NKEYS) && (32'(bus.map_pos) < NKEYS))
        r_map[bus.map_idx] <= bus.map_pos;
    end
  end

  // Position p lives on ts[NKEYS-1-p]; shifting left by p lands it on the MSB.
  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_decode
    logic [NKEYS-1:0] w_sh;
    assign w_sh    = r_ts << r_map[gi];
    assign w_l[gi] = w_sh[NKEYS-1];
  end

  // Exactly one active logical key gives a candidate; idx forced to 0 on NONE
  // so the candidate compare below only sees one encoding of NONE.
  always_comb begin
    w_cand_v   = 1'b0;
    w_cand_idx = '0;
    if ((w_l != '0) && ((w_l & (w_l - NKEYS'(1))) == '0)) begin
      w_cand_v = 1'b1;
      for (int i = 0; i < NKEYS; i++) begin
        if (w_l[i]) w_cand_idx = POS_W'(i);
      end
    end
  end

  assign w_same    = (w_cand_v == r_cq_v) && (w_cand_idx == r_cq_idx);
  // Commit keeps firing while the candidate stays stable; the FSM treats
  // repeated commits of the same value as no-ops.
  assign w_commit  = w_same && (r_cnt == c_DEB_LAST);
  assign w_mute    = r_cq_v && (r_cq_idx == c_MUTE);
  assign w_keynote = r_cq_v && (r_cq_idx != c_MUTE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cq_v   <= 1'b0;
      r_cq_idx <= '0;
      r_cnt    <= '0;
    end else if (!w_same) begin
      r_cq_v   <= w_cand_v;
      r_cq_idx <= w_cand_idx;
      r_cnt    <= '0;
    end else if (r_cnt != c_DEB_LAST) begin
      r_cnt <= r_cnt + c_DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_note  <= '0;
      r_start <= 1'b0;
      r_scnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_key   <= w_key_nx;
      r_note  <= w_note_nx;
      r_start <= w_start_nx;
      r_scnt  <= w_scnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_note_nx  = r_note;
    w_start_nx = 1'b0;
    w_scnt_nx  = r_scnt;
    case (r_state)
      S_IDLE: begin
        if (w_commit && w_keynote) begin
          w_state_nx = S_PLAY;
          w_key_nx   = r_cq_idx;
          w_note_nx  = f_note(r_cq_idx, bus.oct_sel);
          w_start_nx = (w_note_nx != '0);
        end
      end
      S_PLAY: begin
        if (w_commit && w_mute) begin
          w_state_nx = S_IDLE;
          w_note_nx  = '0;
        end else if (w_commit && !r_cq_v) begin
          if (c_HAS_SUS) begin
            w_state_nx = S_SUSTAIN;
            w_scnt_nx  = '0;
          end else begin
            w_state_nx = S_IDLE;
            w_note_nx  = '0;
          end
        end else begin
          // New key or octave change both land here: recompute every cycle.
          // The r_start guard stops back-to-back pulses from rapid oct_sel
          // toggling.
          if (w_commit && w_keynote) w_key_nx = r_cq_idx;
          w_note_nx  = f_note(w_key_nx, bus.oct_sel);
          w_start_nx = (w_note_nx != '0) && (w_note_nx != r_note) && !r_start;
        end
      end
      S_SUSTAIN: begin
        // A re-strike takes priority over expiry landing on the same cycle.
        if (w_commit && w_keynote) begin
          w_state_nx = S_PLAY;
          w_key_nx   = r_cq_idx;
          w_note_nx  = f_note(r_cq_idx, bus.oct_sel);
          w_start_nx = (w_note_nx != '0);
        end else if (w_commit && w_mute) begin
          w_state_nx = S_IDLE;
          w_note_nx  = '0;
        end else if (r_scnt == c_SUS_LAST) begin
          w_state_nx = S_IDLE;
          w_note_nx  = '0;
        end else begin
          w_scnt_nx = r_scnt + c_SUS_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_note_nx  = '0;
      end
    endcase
  end

  assign bus.note       = r_note;
  assign bus.playing    = (r_state != S_IDLE);
  assign bus.note_start = r_start;
  assign bus.multi_err  = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_free_mode_core.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_free_mode_core
// Purpose  : Directed self-checking bench for free_mode_core. Two instances
//            share stimulus: dut0 without sustain, dut1 with a 5-cycle
//            sustain; both debounce for 4 cycles.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_free_mode_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  free_mode_core_if #(.NKEYS(8), .NOTE_W(5), .POS_W(3)) bus0 ();
  free_mode_core_if #(.NKEYS(8), .NOTE_W(5), .POS_W(3)) bus1 ();

  free_mode_core #(
    .NKEYS(8), .NOCT(3), .DEB_CYCLES(4), .SUSTAIN_CYCLES(0), .NOTE_W(5), .POS_W(3)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  free_mode_core #(
    .NKEYS(8), .NOCT(3), .DEB_CYCLES(4), .SUSTAIN_CYCLES(5), .NOTE_W(5), .POS_W(3)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] oct, input logic [7:0] t);
    bus0.oct_sel = oct;
    bus1.oct_sel = oct;
    bus0.touch   = t;
    bus1.touch   = t;
  endtask

  task automatic map_write(input logic [2:0] idx, input logic [2:0] pos);
    bus0.map_wr = 1'b1; bus1.map_wr = 1'b1;
    bus0.map_idx = idx; bus1.map_idx = idx;
    bus0.map_pos = pos; bus1.map_pos = pos;
    tick();
    bus0.map_wr = 1'b0; bus1.map_wr = 1'b0;
  endtask

  task automatic do_reset();
    drive(2'd0, 8'h00);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus0.map_wr = 1'b0; bus1.map_wr = 1'b0;
    bus0.map_idx = '0; bus1.map_idx = '0;
    bus0.map_pos = '0; bus1.map_pos = '0;
    do_reset();
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b0 || bus0.note_start !== 1'b0 || bus0.multi_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut0 got note=%0d play=%b start=%b multi=%b want 0 0 0 0",
               bus0.note, bus0.playing, bus0.note_start, bus0.multi_err);
    end
    total++;
    if (bus1.note !== 5'd0 || bus1.playing !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut1 got note=%0d play=%b want 0 0", bus1.note, bus1.playing);
    end
  endtask

  task automatic test_basic();
    int starts = 0;
    drive(2'd1, 8'b0010_0000);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus0.note_start === 1'b1) starts++;
      if (c == 6) begin
        total++;
        if (bus0.note !== 5'd0) begin
          bad++; $display("FAIL basic_early got=%0d want=0", bus0.note);
        end
      end
      if (c == 7) begin
        total++;
        if (bus0.note !== 5'd10 || bus0.note_start !== 1'b1 || bus0.playing !== 1'b1) begin
          bad++;
          $display("FAIL basic_on got note=%0d start=%b play=%b want 10 1 1",
                   bus0.note, bus0.note_start, bus0.playing);
        end
      end
    end
    total++;
    if (starts != 1) begin
      bad++; $display("FAIL basic_pulses got=%0d want=1", starts);
    end
    drive(2'd1, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 6) begin
        total++;
        if (bus0.note !== 5'd10) begin
          bad++; $display("FAIL basic_hold got=%0d want=10", bus0.note);
        end
      end
    end
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b0) begin
      bad++; $display("FAIL basic_off got note=%0d play=%b want 0 0", bus0.note, bus0.playing);
    end
  endtask

  task automatic test_glitch();
    int starts = 0;
    int nz = 0;
    do_reset();
    drive(2'd1, 8'b1000_0000);
    tick(); tick(); tick();
    drive(2'd1, 8'h00);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus0.note_start !== 1'b0) starts++;
      if (bus0.note !== 5'd0) nz++;
    end
    total++;
    if (starts != 0 || nz != 0) begin
      bad++; $display("FAIL glitch got starts=%0d nonzero=%0d want 0 0", starts, nz);
    end
  endtask

  task automatic test_multi_mute();
    do_reset();
    drive(2'd1, 8'b1100_0000);
    tick(); tick();
    total++;
    if (bus0.multi_err !== 1'b0) begin
      bad++; $display("FAIL multi_early got=%b want=0", bus0.multi_err);
    end
    tick();
    total++;
    if (bus0.multi_err !== 1'b1) begin
      bad++; $display("FAIL multi_set got=%b want=1", bus0.multi_err);
    end
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b0) begin
      bad++; $display("FAIL multi_note got note=%0d play=%b want 0 0", bus0.note, bus0.playing);
    end
    drive(2'd2, 8'b1000_0000);
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus0.note !== 5'd15 || bus0.multi_err !== 1'b0) begin
      bad++; $display("FAIL mute_pre got note=%0d multi=%b want 15 0", bus0.note, bus0.multi_err);
    end
    drive(2'd2, 8'b0000_0001);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 6) begin
        total++;
        if (bus0.note !== 5'd15) begin
          bad++; $display("FAIL mute_hold got=%0d want=15", bus0.note);
        end
      end
    end
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b0) begin
      bad++; $display("FAIL mute_off got note=%0d play=%b want 0 0", bus0.note, bus0.playing);
    end
    total++;
    if (bus1.note !== 5'd0 || bus1.playing !== 1'b0) begin
      bad++; $display("FAIL mute_nosus got note=%0d play=%b want 0 0", bus1.note, bus1.playing);
    end
  endtask

  task automatic test_remap();
    do_reset();
    // swap do and mute so position 7 belongs to key 0 alone
    map_write(3'd0, 3'd7);
    map_write(3'd7, 3'd0);
    drive(2'd0, 8'b0000_0001);
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus0.note !== 5'd1 || bus0.multi_err !== 1'b0) begin
      bad++; $display("FAIL remap_note got note=%0d multi=%b want 1 0", bus0.note, bus0.multi_err);
    end
    map_write(3'd1, 3'd7);
    tick();
    total++;
    if (bus0.multi_err !== 1'b1) begin
      bad++; $display("FAIL remap_dup got=%b want=1", bus0.multi_err);
    end
    tick(); tick(); tick();
    total++;
    if (bus0.note !== 5'd1) begin
      bad++; $display("FAIL remap_hold got=%0d want=1", bus0.note);
    end
    tick();
    total++;
    if (bus0.note !== 5'd0) begin
      bad++; $display("FAIL remap_dup_note got=%0d want=0", bus0.note);
    end
  endtask

  task automatic test_sustain();
    do_reset();
    drive(2'd0, 8'b0010_0000);
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus1.note !== 5'd3 || bus1.note_start !== 1'b1) begin
      bad++; $display("FAIL sus_on got note=%0d start=%b want 3 1", bus1.note, bus1.note_start);
    end
    // plain release: five held cycles after the release commit, then silence
    drive(2'd0, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 11) begin
        total++;
        if (bus1.note !== 5'd3 || bus1.playing !== 1'b1) begin
          bad++; $display("FAIL sus_held got note=%0d play=%b want 3 1", bus1.note, bus1.playing);
        end
      end
    end
    total++;
    if (bus1.note !== 5'd0 || bus1.playing !== 1'b0) begin
      bad++; $display("FAIL sus_expire got note=%0d play=%b want 0 0", bus1.note, bus1.playing);
    end
    drive(2'd0, 8'b0010_0000);
    for (int c = 0; c < 7; c++) tick();
    // release, then strike the same key again inside the sustain window
    drive(2'd0, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 5) drive(2'd0, 8'b0010_0000);
      if (c == 11) begin
        total++;
        if (bus1.note !== 5'd3 || bus1.note_start !== 1'b0) begin
          bad++; $display("FAIL sus_pre got note=%0d start=%b want 3 0", bus1.note, bus1.note_start);
        end
      end
    end
    total++;
    if (bus1.note !== 5'd3 || bus1.note_start !== 1'b1 || bus1.playing !== 1'b1) begin
      bad++;
      $display("FAIL sus_restrike got note=%0d start=%b play=%b want 3 1 1",
               bus1.note, bus1.note_start, bus1.playing);
    end
    tick(); tick(); tick();
    total++;
    if (bus1.note !== 5'd3 || bus1.playing !== 1'b1) begin
      bad++; $display("FAIL sus_play got note=%0d play=%b want 3 1", bus1.note, bus1.playing);
    end
  endtask

  task automatic test_octave();
    do_reset();
    drive(2'd1, 8'b1000_0000);
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus0.note !== 5'd8) begin
      bad++; $display("FAIL oct_base got=%0d want=8", bus0.note);
    end
    tick();
    drive(2'd2, 8'b1000_0000);
    tick();
    total++;
    if (bus0.note !== 5'd15 || bus0.note_start !== 1'b1) begin
      bad++; $display("FAIL oct_up got note=%0d start=%b want 15 1", bus0.note, bus0.note_start);
    end
    drive(2'd3, 8'b1000_0000);
    tick();
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b1 || bus0.note_start !== 1'b0) begin
      bad++;
      $display("FAIL oct_bad got note=%0d play=%b start=%b want 0 1 0",
               bus0.note, bus0.playing, bus0.note_start);
    end
    drive(2'd1, 8'b1000_0000);
    tick();
    total++;
    if (bus0.note !== 5'd8 || bus0.note_start !== 1'b1) begin
      bad++; $display("FAIL oct_back got note=%0d start=%b want 8 1", bus0.note, bus0.note_start);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    map_write(3'd0, 3'd7);
    drive(2'd1, 8'b1000_0000);
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus0.note !== 5'd0 || bus0.playing !== 1'b0 || bus0.note_start !== 1'b0 || bus0.multi_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_out got note=%0d play=%b start=%b multi=%b want 0 0 0 0",
               bus0.note, bus0.playing, bus0.note_start, bus0.multi_err);
    end
    rst = 1'b1;
    // identity map restored: position 0 decodes as do again
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (bus0.note !== 5'd8) begin
      bad++; $display("FAIL rstmid_map got=%0d want=8", bus0.note);
    end
  endtask

  initial begin
    drive(2'd0, 8'h00);
    test_reset();
    test_basic();
    test_glitch();
    test_multi_mute();
    test_remap();
    test_sustain();
    test_octave();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/free_mode_core.md
Name: free_mode_core

Overview:
- Parametrised successor to the free-play key decoder: maps an NKEYS-wide touch bus to a note number across NOCT octaves.
- Adds a runtime-writable key-position table, input synchronisation and debounce, single-key legality checking, and an optional release sustain.
- Sits between the board key inputs and the tone generator; `note` drives the tone generator's note-select input directly.

Parameters:
- NKEYS, 8, touch width; logical keys 0..NKEYS-2 are notes do..si, logical key NKEYS-1 is mute.
- NOCT, 3, number of octaves; oct_sel values 0..NOCT-1 are valid.
- DEB_CYCLES, 1000000, cycles a candidate must be stable before commit (≥1).
- SUSTAIN_CYCLES, 0, cycles the note is held after key release; 0 = no sustain.
- NOTE_W, 5, note width; must hold NOCT*(NKEYS-1).
- POS_W, 3, width of a table position; must hold NKEYS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- oct_sel  in  2  octave select, binary 0=bass, 1=mid, 2=high; ≥NOCT is invalid
- touch  in  NKEYS  raw key levels; position p is touch[NKEYS-1-p], i.e. position 0 = MSB
- map_wr  in  1  table write strobe
- map_idx  in  POS_W  logical key being remapped
- map_pos  in  POS_W  new physical position for map_idx
- note  out  NOTE_W  current note; 0 = silence
- playing  out  1  high in PLAY or SUSTAIN
- note_start  out  1  one-cycle pulse on each new nonzero note
- multi_err  out  1  more than one logical key is active (registered)

Behaviour:
- Reset (rst=0 at a clk edge):
  - note=0, playing=0, note_start=0, multi_err=0.
  - FSM state → IDLE; sync flops and counters cleared.
  - map[i]=i for all i.
  - Reset overrides everything, including map_wr and mid-debounce or mid-sustain activity.
- Map table:
  - On map_wr, map[map_idx] ← map_pos at the clk edge.
  - Writes with map_idx or map_pos ≥ NKEYS are ignored.
  - Decoding uses the new entry from the next cycle; any resulting candidate change still goes through debounce.
  - Duplicate positions are allowed; pressing a shared position activates several logical keys, giving multi_err.
- Input path:
  - touch passes through a 2-flop synchroniser → ts.
  - L[i] = ts[NKEYS-1-map[i]].
  - cand = index of the single set bit of L if popcount(L)==1; otherwise NONE (popcount 0 or >1).
  - multi_err ← (popcount(L)>1), updated every cycle.
- Debounce:
  - Registered cand_q and counter cnt.
  - If cand≠cand_q: cand_q←cand, cnt←0.
  - Else if cnt==DEB_CYCLES-1: commit cand_q, cnt holds.
  - Else: cnt increments.
  - A touch change held stable reaches note exactly DEB_CYCLES+3 cycles later.
  - Glitches shorter than DEB_CYCLES never commit.
- Note value:
  - Note key k (k<NKEYS-1) at octave o: note = o*(NKEYS-1)+k+1. With defaults this gives 1..21.
  - Mute, NONE, or invalid oct_sel → note value 0.
- FSM (IDLE, PLAY, SUSTAIN), evaluated on commit:
  - IDLE: commit of a note key → PLAY; note←value, note_start=1.
  - PLAY, commit of a different note key → PLAY; note←new value, note_start=1.
  - PLAY, commit of NONE → SUSTAIN (note held, sustain counter cleared) if SUSTAIN_CYCLES>0; otherwise → IDLE with note←0.
  - PLAY, commit of mute → IDLE, note←0 immediately; mute bypasses sustain.
  - SUSTAIN: counter reaches SUSTAIN_CYCLES-1 → IDLE, note←0.
  - SUSTAIN: commit of a note key → PLAY with new note and note_start=1; this includes the same key (re-strike).
  - SUSTAIN: commit of mute → IDLE.
- oct_sel changes:
  - In PLAY: note recomputed the next cycle with no debounce.
  - note_start pulses if the new value is nonzero; an invalid octave gives note=0, state stays PLAY.
  - In SUSTAIN: the held note does not change.
- note_start is never asserted while note would be 0, and never on two consecutive cycles.

Test Plan:
- Reset + defaults (DEB_CYCLES=4, SUSTAIN_CYCLES=0), oct_sel=1, touch=8'b0010_0000 held → after 7 cycles note=10, note_start one pulse, playing=1; release → note=0 after 7 cycles.
- Glitch: touch=8'b1000_0000 for 3 cycles, then 0 → note stays 0, note_start never asserted.
- Multi-key: touch=8'b1100_0000 → multi_err=1 after 3 cycles, note stays 0. Mute touch=8'b0000_0001 while note=15 (oct_sel=2, do) → note=0 after 7 cycles, no sustain.
- Remap: map_wr, map_idx=0, map_pos=7; touch=8'b0000_0001, oct_sel=0 → note=1. Duplicate map_idx=1, map_pos=7 → multi_err=1, note 0.
- Sustain (SUSTAIN_CYCLES=5): note=3 then release → note held exactly 5 cycles after commit then 0. Re-press during sustain → note_start pulses, state PLAY.
- Octave and reset: note=8, oct_sel 1→2 → note=15 next cycle with note_start pulse; oct_sel=3 → note=0. rst=0 mid-debounce → all outputs 0 and map back to identity the next cycle.
